wb_arbiter: RTL and testbench

- Write-back arbiter: the writer side of reg_file.
- Merges single-cycle ALU results and handshaked load results into the register file's single write port (wa/wr/wren).
- Buffers load results in a small FIFO and suppresses writes to r0.
- Exports pending-write scoreboard flags to the issue stage.

---
 rtl/wb_arbiter_pkg.sv | 21 ++
 rtl/wb_arbiter_fifo.sv | 85 ++++++++
 rtl/wb_arbiter.sv | 151 +++++++++++++++
 tb/tb_wb_arbiter.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/wb_arbiter_pkg.sv
// Shared write-back types and constants.
// Used by wb_arbiter, reg_file and decode.
package wb_arbiter_pkg;

  localparam int REG_AW = 5;
  localparam int REG_DW = 32;
  localparam logic [REG_AW-1:0] REG_ZERO = 5'd0;

  typedef struct packed {
    logic [REG_AW-1:0] wa;
    logic [REG_DW-1:0] wd;
  } wb_entry_t;

  function automatic logic addr_hit(
    input logic [REG_AW-1:0] a,
    input logic [REG_AW-1:0] b
  );
    return (a == b) && (b != REG_ZERO);
  endfunction

endpackage

// File: rtl/wb_arbiter_fifo.sv
// wb_fifo: load-result queue for the write-back arbiter.
// Exposes per-entry valid/wa vectors for the scoreboard.
module wb_fifo
  import wb_arbiter_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                         clk,
  input  logic                         rstd,
  input  logic                         push,
  input  logic                         pop,
  input  wb_entry_t                    din,
  output wb_entry_t                    dout,
  output logic [$clog2(DEPTH):0]       count,
  output logic                         full,
  output logic                         empty,
  output logic [DEPTH-1:0]             ent_vld,
  output logic [DEPTH-1:0][REG_AW-1:0] ent_wa
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  wb_entry_t        mem_q [DEPTH];
  wb_entry_t        mem_d [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;

  // next-state for storage, wrapping pointers and occupancy
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) begin
      mem_d[wr_ptr_q] = din;
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    if (push && !pop) begin
      count_d = count_q + 1'b1;
    end else if (pop && !push) begin
      count_d = count_q - 1'b1;
    end
  end

  // queue state; reset empties the queue
  always_ff @(posedge clk or posedge rstd) begin
    if (rstd) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // an entry is live when its offset from the head is below count
  always_comb begin
    logic [PW-1:0] off;
    ent_vld = '0;
    ent_wa  = '0;
    off     = '0;
    for (int i = 0; i < DEPTH; i++) begin
      off        = PW'(i) - rd_ptr_q;
      ent_vld[i] = ({1'b0, off} < count_q);
      ent_wa[i]  = mem_q[i].wa;
    end
  end

  assign dout  = mem_q[rd_ptr_q];
  assign count = count_q;
  assign full  = (count_q == CW'(DEPTH));
  assign empty = (count_q == '0);

endmodule

// File: rtl/wb_arbiter.sv
// Write-back arbiter: merges ALU and load results into one write port.
// Optional macro WB_FWD_EN adds in-flight write forwarding ports.
module wb_arbiter
  import wb_arbiter_pkg::*;
#(
  parameter int DEPTH      = 2,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              rstd,
  input  logic              alu_valid,
  input  logic [REG_AW-1:0] alu_wa,
  input  logic [REG_DW-1:0] alu_wd,
  input  logic              ld_valid,
  output logic              ld_ready,
  input  logic [REG_AW-1:0] ld_wa,
  input  logic [REG_DW-1:0] ld_wd,
  output logic              alu_stall,
  input  logic [REG_AW-1:0] ra1,
  input  logic [REG_AW-1:0] ra2,
  input  logic [REG_AW-1:0] qwa,
  output logic              busy1,
  output logic              busy2,
  output logic              busyw,
`ifdef WB_FWD_EN
  output logic              fwd1,
  output logic              fwd2,
  output logic [REG_DW-1:0] fwdd1,
  output logic [REG_DW-1:0] fwdd2,
`endif
  output logic [REG_AW-1:0] wa,
  output logic [REG_DW-1:0] wr,
  output logic              wren
);

  localparam int SW = $clog2(STARVE_MAX + 1);
  localparam logic [SW-1:0] STARVE_LAST = SW'(STARVE_MAX - 1);

  logic                         alu_w, push, pop, blocked;
  logic                         full, empty;
  logic [$clog2(DEPTH):0]       fifo_cnt;
  logic [DEPTH-1:0]             ent_vld;
  logic [DEPTH-1:0][REG_AW-1:0] ent_wa;
  wb_entry_t                    head;
  wb_entry_t                    ld_ent;

  logic [REG_AW-1:0] wa_q, wa_d;
  logic [REG_DW-1:0] wr_q, wr_d;
  logic              wren_q, wren_d;
  logic              stall_q, stall_d;
  logic [SW-1:0]     starve_q, starve_d;

  assign ld_ent = '{wa: ld_wa, wd: ld_wd};

  // a stalled ALU result is dropped so the drain always wins
  assign alu_w   = alu_valid && (alu_wa != REG_ZERO) && !stall_q;
  assign push    = ld_valid && !full && (ld_wa != REG_ZERO);
  assign pop     = !alu_w && !empty;
  assign blocked = alu_w && !empty;

  wb_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .rstd    (rstd),
    .push    (push),
    .pop     (pop),
    .din     (ld_ent),
    .dout    (head),
    .count   (fifo_cnt),
    .full    (full),
    .empty   (empty),
    .ent_vld (ent_vld),
    .ent_wa  (ent_wa)
  );

  // pick ALU first, else drain the queue head, else idle
  always_comb begin
    wa_d     = wa_q;
    wr_d     = wr_q;
    wren_d   = 1'b0;
    stall_d  = 1'b0;
    starve_d = '0;
    if (alu_w) begin
      wren_d = 1'b1;
      wa_d   = alu_wa;
      wr_d   = alu_wd;
    end else if (pop) begin
      wren_d = 1'b1;
      wa_d   = head.wa;
      wr_d   = head.wd;
    end
    if (blocked) begin
      if (starve_q == STARVE_LAST) begin
        stall_d = 1'b1;
      end else begin
        starve_d = starve_q + 1'b1;
      end
    end
  end

  // registered write port and starvation state
  always_ff @(posedge clk or posedge rstd) begin
    if (rstd) begin
      wa_q     <= '0;
      wr_q     <= '0;
      wren_q   <= 1'b0;
      stall_q  <= 1'b0;
      starve_q <= '0;
    end else begin
      wa_q     <= wa_d;
      wr_q     <= wr_d;
      wren_q   <= wren_d;
      stall_q  <= stall_d;
      starve_q <= starve_d;
    end
  end

  // scoreboard: any live queued load targeting the query register
  always_comb begin
    busy1 = 1'b0;
    busy2 = 1'b0;
    busyw = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (ent_vld[i]) begin
        busy1 = busy1 | addr_hit(ent_wa[i], ra1);
        busy2 = busy2 | addr_hit(ent_wa[i], ra2);
        busyw = busyw | addr_hit(ent_wa[i], qwa);
      end
    end
  end

  assign ld_ready  = !full;
  assign alu_stall = stall_q;
  assign wa        = wa_q;
  assign wr        = wr_q;
  assign wren      = wren_q;

`ifdef WB_FWD_EN
  assign fwd1  = wren_q && addr_hit(wa_q, ra1);
  assign fwd2  = wren_q && addr_hit(wa_q, ra2);
  assign fwdd1 = wr_q;
  assign fwdd2 = wr_q;
`endif

`ifndef SYNTHESIS
  a_no_alu_in_stall: assert property (
    @(posedge clk) disable iff (rstd) !(stall_q && alu_valid));
  a_cnt_range: assert property (
    @(posedge clk) disable iff (rstd) fifo_cnt <= DEPTH);
`endif

endmodule

// File: tb/tb_wb_arbiter.sv
// Directed + random bench for wb_arbiter.
// Reference model: queue of pending loads plus starvation count.
module tb_wb_arbiter;
  import wb_arbiter_pkg::*;

  localparam int DEPTH = 2;
  localparam int SMAX  = 4;

  logic        clk = 1'b0;
  logic        rstd = 1'b0;
  logic        alu_valid = 1'b0;
  logic [4:0]  alu_wa = '0;
  logic [31:0] alu_wd = '0;
  logic        ld_valid = 1'b0;
  logic        ld_ready;
  logic [4:0]  ld_wa = '0;
  logic [31:0] ld_wd = '0;
  logic        alu_stall;
  logic [4:0]  ra1 = '0, ra2 = '0, qwa = '0;
  logic        busy1, busy2, busyw;
  logic [4:0]  wa;
  logic [31:0] wr;
  logic        wren;
`ifdef WB_FWD_EN
  logic        fwd1, fwd2;
  logic [31:0] fwdd1, fwdd2;
`endif

  wb_arbiter #(.DEPTH(DEPTH), .STARVE_MAX(SMAX)) dut (
    .clk       (clk),
    .rstd      (rstd),
    .alu_valid (alu_valid),
    .alu_wa    (alu_wa),
    .alu_wd    (alu_wd),
    .ld_valid  (ld_valid),
    .ld_ready  (ld_ready),
    .ld_wa     (ld_wa),
    .ld_wd     (ld_wd),
    .alu_stall (alu_stall),
    .ra1       (ra1),
    .ra2       (ra2),
    .qwa       (qwa),
    .busy1     (busy1),
    .busy2     (busy2),
    .busyw     (busyw),
`ifdef WB_FWD_EN
    .fwd1      (fwd1),
    .fwd2      (fwd2),
    .fwdd1     (fwdd1),
    .fwdd2     (fwdd2),
`endif
    .wa        (wa),
    .wr        (wr),
    .wren      (wren)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [4:0]  wa;
    logic [31:0] wd;
  } ld_t;

  ld_t         q[$];
  int          starve = 0;
  logic        e_wren = 1'b0;
  logic [4:0]  e_wa = '0;
  logic [31:0] e_wr = '0;
  logic        e_stall = 1'b0;
  logic        hold = 1'b0;

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s obs=%h exp=%h", tag, obs, exp);
    end
  endtask

  function automatic logic m_busy(logic [4:0] a);
    foreach (q[i]) if (a != 0 && q[i].wa == a) return 1'b1;
    return 1'b0;
  endfunction

  task automatic drive(logic av, logic [4:0] awa, logic [31:0] awd,
                       logic lv, logic [4:0] lwa, logic [31:0] lwd);
    alu_valid = av;
    alu_wa    = awa;
    alu_wd    = awd;
    ld_valid  = lv;
    ld_wa     = lwa;
    ld_wd     = lwd;
  endtask

  // check outputs against the model, advance model, clock once
  task automatic cycle();
    logic rdy, aw, pop, blk;
    #1;
    rdy = (q.size() < DEPTH);
    chk("ld_ready", ld_ready, rdy);
    chk("busy1", busy1, m_busy(ra1));
    chk("busy2", busy2, m_busy(ra2));
    chk("busyw", busyw, m_busy(qwa));
    chk("wren", wren, e_wren);
    chk("wa", wa, e_wa);
    chk("wr", wr, e_wr);
    chk("alu_stall", alu_stall, e_stall);
`ifdef WB_FWD_EN
    chk("fwd1", fwd1, e_wren && e_wa == ra1 && ra1 != 0);
    chk("fwd2", fwd2, e_wren && e_wa == ra2 && ra2 != 0);
    chk("fwdd1", fwdd1, e_wr);
    chk("fwdd2", fwdd2, e_wr);
`endif
    aw  = alu_valid && alu_wa != 0 && !e_stall;
    pop = !aw && q.size() > 0;
    blk = aw && q.size() > 0;
    e_stall = blk && (starve == SMAX - 1);
    if (blk) starve = (starve == SMAX - 1) ? 0 : starve + 1;
    else     starve = 0;
    if (aw) begin
      e_wren = 1'b1; e_wa = alu_wa; e_wr = alu_wd;
    end else if (pop) begin
      e_wren = 1'b1; e_wa = q[0].wa; e_wr = q[0].wd;
    end else begin
      e_wren = 1'b0;
    end
    if (pop) void'(q.pop_front());
    if (ld_valid && rdy && ld_wa != 0) begin
      ld_t e;
      e.wa = ld_wa;
      e.wd = ld_wd;
      q.push_back(e);
    end
    hold = ld_valid && !rdy;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rstd = 1'b1;
    #1;
    chk("rst_ld_ready", ld_ready, 1);
    chk("rst_busy1", busy1, 0);
    chk("rst_busy2", busy2, 0);
    chk("rst_busyw", busyw, 0);
    chk("rst_wren", wren, 0);
    chk("rst_wa", wa, 0);
    chk("rst_wr", wr, 0);
    chk("rst_stall", alu_stall, 0);
    @(posedge clk);
    #1;
    chk("rst_wren_hold", wren, 0);
    chk("rst_ready_hold", ld_ready, 1);
    rstd = 1'b0;
    q.delete();
    starve  = 0;
    e_wren  = 1'b0;
    e_wa    = '0;
    e_wr    = '0;
    e_stall = 1'b0;
    hold    = 1'b0;
  endtask

  initial begin
    #1;
    do_reset();

    // ALU write with empty queue, then ALU to r0
    drive(1, 5, 32'h12345678, 0, 0, 0);
    cycle();
    chk("alu_r5_wren", wren, 1);
    chk("alu_r5_wa", wa, 5);
    chk("alu_r5_wr", wr, 32'h12345678);
    drive(1, 0, 32'hCAFEF00D, 0, 0, 0);
    cycle();
    chk("alu_r0_wren", wren, 0);

    // single load, idle ALU
    ra1 = 6;
    drive(0, 0, 0, 1, 6, 32'h87654321);
    cycle();
    chk("ld_r6_busy", busy1, 1);
    drive(0, 0, 0, 0, 0, 0);
    cycle();
    chk("ld_r6_wren", wren, 1);
    chk("ld_r6_wa", wa, 6);
    chk("ld_r6_wr", wr, 32'h87654321);
    chk("ld_r6_busy_clr", busy1, 0);
    cycle();

    // fill the queue under continuous ALU traffic
    ra1 = 1; ra2 = 2; qwa = 3;
    drive(1, 10, 32'hA0, 1, 1, 32'h111);
    cycle();
    drive(1, 11, 32'hA1, 1, 2, 32'h222);
    cycle();
    drive(1, 12, 32'hA2, 1, 3, 32'h333);
    chk("full_ready", ld_ready, 0);
    cycle();
    drive(1, 13, 32'hA3, 1, 3, 32'h333);
    cycle();
    drive(1, 14, 32'hA4, 1, 3, 32'h333);
    cycle();
    chk("starve_stall", alu_stall, 1);
    drive(0, 0, 0, 1, 3, 32'h333);
    cycle();
    chk("stall_drain_wa", wa, 1);
    chk("stall_drain_wr", wr, 32'h111);
    chk("stall_one_cycle", alu_stall, 0);
    cycle();
    drive(0, 0, 0, 0, 0, 0);
    repeat (4) cycle();

    // ALU and load in the same cycle; load to r0 dropped
    drive(1, 7, 32'h77777777, 1, 8, 32'h11111111);
    cycle();
    chk("same_alu_wa", wa, 7);
    drive(0, 0, 0, 1, 0, 32'hDEADBEEF);
    cycle();
    chk("same_ld_wa", wa, 8);
    chk("same_ld_wr", wr, 32'h11111111);
    drive(0, 0, 0, 0, 0, 0);
    cycle();
    cycle();
    chk("r0_never", wren, 0);

    // write in flight visible to forwarding
    ra1 = 0; ra2 = 9;
    drive(1, 9, 32'hBBBBBBBB, 0, 0, 0);
    cycle();
`ifdef WB_FWD_EN
    chk("fwd2_hit", fwd2, 1);
    chk("fwdd2_val", fwdd2, 32'hBBBBBBBB);
    chk("fwd1_r0", fwd1, 0);
`endif
    chk("r9_wa", wa, 9);
    drive(0, 0, 0, 0, 0, 0);
    cycle();

    // reset with two loads queued
    drive(1, 5, 32'h1, 1, 3, 32'hAAAAAAAA);
    cycle();
    drive(1, 5, 32'h2, 1, 4, 32'h55555555);
    cycle();
    drive(0, 0, 0, 0, 0, 0);
    ra1 = 3; ra2 = 4; qwa = 4;
    #1;
    chk("pre_rst_busy1", busy1, 1);
    chk("pre_rst_busyw", busyw, 1);
    do_reset();
    repeat (3) begin
      cycle();
      chk("post_rst_nowr", wren, 0);
    end

    // randomized traffic
    for (int n = 0; n < 400; n++) begin
      alu_valid = !e_stall && ($urandom_range(0, 2) != 0);
      alu_wa    = 5'($urandom_range(0, 7));
      alu_wd    = $urandom;
      if (!hold) begin
        ld_valid = ($urandom_range(0, 1) != 0);
        ld_wa    = 5'($urandom_range(0, 7));
        ld_wd    = $urandom;
      end
      ra1 = 5'($urandom_range(0, 7));
      ra2 = 5'($urandom_range(0, 7));
      qwa = 5'($urandom_range(0, 7));
      cycle();
    end
    drive(0, 0, 0, 0, 0, 0);
    repeat (4) cycle();

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
